// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 PIC subsystem: acknowledge FSM states,
// default INTA timing and the vector width seen by both CPU and PIC sides.
package pic_pkg;

    localparam int unsigned VEC_W       = 8;
    localparam int unsigned PULSE_W_DEF = 4;
    localparam int unsigned GAP_W_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        GAP  = 3'd2,
        P2   = 3'd3,
        DONE = 3'd4,
        HOLD = 3'd5
    } inta_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One spare bit so a single counter covers both pulse and gap reloads.
    function automatic int unsigned cnt_width(input int unsigned pw, input int unsigned gw);
        return $clog2(max_u(pw, gw)) + 1;
    endfunction

endpackage

// File: rtl/pic_sync2.sv
// Generic two-flop synchronizer with synchronous reset for asynchronous
// PIC-side levels.
module pic_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator: issues the two-pulse INTA
// sequence to the master PIC and captures the vector from the second pulse.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intr,
    input  logic             ack_en,
    input  logic [VEC_W-1:0] data_in,
    output logic             inta_n,
    output logic             lock_n,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(PULSE_W, GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    if (PULSE_W == 0) begin : g_bad_pulse_w
        $error("inta_sequencer: PULSE_W must be at least 1");
    end
    if (GAP_W == 0) begin : g_bad_gap_w
        $error("inta_sequencer: GAP_W must be at least 1");
    end

    logic [0:0] intr_s;
    inta_state_e state;
    logic [CNT_W-1:0] cnt;
    logic cnt_zero;

    pic_sync2 #(.W(1)) u_intr_sync (
        .clk (clk),
        .rst (rst),
        .d   (intr),
        .q   (intr_s)
    );

    assign cnt_zero = (cnt == '0);

    // Sequencer: every state entry reloads the shared down-counter and sets
    // the strobe levels for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            inta_n       <= 1'b1;
            lock_n       <= 1'b1;
            vector       <= '0;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vector_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (intr_s[0] && ack_en) begin
                        state  <= P1;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                        lock_n <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                P1: begin
                    if (cnt_zero) begin
                        state  <= GAP;
                        cnt    <= GAP_LD;
                        inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state  <= P2;
                        cnt    <= PULSE_LD;
                        inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                P2: begin
                    // Last cycle of pulse 2: the PIC is driving the vector now.
                    if (cnt_zero) begin
                        state        <= DONE;
                        cnt          <= '0;
                        inta_n       <= 1'b1;
                        lock_n       <= 1'b1;
                        vector       <= data_in;
                        vector_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // Wait out the stale INT level before re-arming.
                    if (!intr_s[0]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    inta_n <= 1'b1;
                    lock_n <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

CPU-side interrupt-acknowledge initiator for the 8259 PIC subsystem. It watches the master PIC's INT line and, when the processor side allows it, generates the two-pulse INTA sequence that the PIC cascade/vector logic responds to. It then captures the vector byte driven on the data bus during the second pulse and hands it to the core with a one-cycle valid strobe.

## Interface
- PULSE_W, 4: cycles `inta_n` is held low per pulse; must be ≥1
- GAP_W, 2: cycles `inta_n` is held high between pulse 1 and pulse 2; must be ≥1
- clk  in  1  sole clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- intr  in  1  INT from the master PIC; asynchronous level
- ack_en  in  1  core permits acknowledge (interrupt-enable flag); sampled only in IDLE
- data_in  in  8  PIC data bus; valid during pulse 2
- inta_n  out  1  interrupt-acknowledge strobe, active low
- lock_n  out  1  bus lock, active low; spans the whole sequence
- vector  out  8  captured vector byte; holds until the next capture
- vector_valid  out  1  one-cycle strobe marking a new `vector`
- busy  out  1  high whenever state ≠ IDLE

## Operation
- `intr` passes through a 2-flop synchronizer to give `intr_s`. Nothing else uses raw `intr`.
- States:
  - IDLE → P1 when `intr_s & ack_en`.
  - P1 (`inta_n`=0, PULSE_W cycles) → GAP.
  - GAP (`inta_n`=1, GAP_W cycles) → P2.
  - P2 (`inta_n`=0, PULSE_W cycles) → DONE.
  - DONE (1 cycle) → HOLD.
  - HOLD → IDLE when `intr_s`=0.
- A single down-counter, width clog2(max(PULSE_W,GAP_W))+1, is loaded on each state entry.
- `lock_n`=0 in P1, GAP and P2; 1 elsewhere.
- `data_in` is registered into `vector` on the last cycle of P2. `vector_valid`=1 during DONE only.
- HOLD blocks re-acknowledging a stale INT level. A new sequence requires `intr_s` to return low first.
- If `intr_s` falls after leaving IDLE, the full sequence still completes and the vector is captured. The PIC returns its spurious vector in that case, and handling it is the core's job.
- `ack_en` is ignored outside IDLE.
- All outputs are registered.

## Timing
- Reset values: `inta_n`=1, `lock_n`=1, `vector`=8'h00, `vector_valid`=0, `busy`=0. State is IDLE and the synchronizer is cleared.
- Reset asserted mid-sequence (any state): on the next edge all outputs take their reset values. No partial pulse is extended, and any vector capture in progress is discarded.
- `intr` rising to the first `inta_n` low takes 3 edges: 2 synchronizer edges plus the IDLE→P1 edge. With `ack_en` already high, `inta_n` falls at edge E.
- Defaults (PULSE_W=4, GAP_W=2):
  - `inta_n` low during cycles E..E+3, high during E+4..E+5, low during E+6..E+9.
  - `data_in` is sampled at the edge ending cycle E+9. `vector_valid` is high during cycle E+10.
  - `lock_n` is low for cycles E..E+9.
- General sequence length: 2·PULSE_W+GAP_W cycles with `inta_n` active, plus 1 DONE cycle.
- Minimum back-to-back spacing: HOLD → IDLE takes at least 1 cycle after `intr_s` falls. Re-synchronizing a new `intr` rise adds 2 more.
- `rst` and `intr` rising together: reset wins, and the INT is recognized afresh after reset releases.

## Structure
- Shared package `pic_pkg` holds:
  - the FSM state enum (IDLE, P1, GAP, P2, DONE, HOLD);
  - the default PULSE_W/GAP_W constants;
  - the vector-width constant (8), shared with the PIC side.
- Sub-module `pic_sync2`: generic 2-flop synchronizer with synchronous reset. It is reused by other asynchronous PIC inputs.
- Parameter legality (≥1) is checked at elaboration.

## Test plan
- Reset and basic sequence: assert `rst` 3 cycles, then `intr`=1 with `ack_en`=1 and `data_in`=8'h4A during P2. Expect:
  - `inta_n` low 4 / high 2 / low 4;
  - `lock_n` low for 10 cycles;
  - `vector`=8'h4A with `vector_valid` for exactly 1 cycle;
  - `busy` high until `intr` drops.
- Gated acknowledge: `intr`=1, `ack_en`=0 for 20 cycles, then `ack_en`=1. Expect no `inta_n` activity until 1 edge after `ack_en` rises; `ack_en` dropping during P2 does not abort the sequence.
- Stale-level block: hold `intr`=1 after DONE for 15 cycles. Expect exactly one sequence and `busy`=1 in HOLD. Drop `intr`, then re-raise it: expect a second sequence.
- Spurious: `intr` pulses high for 4 cycles only, with `data_in`=8'h47. Expect the full two-pulse sequence and `vector`=8'h47 captured.
- Reset mid-operation: assert `rst` during cycle E+7 (inside P2). Expect at the next edge `inta_n`=1, `lock_n`=1, `vector`=8'h00, `vector_valid`=0, and no later strobe.
- Parameter sweep: PULSE_W=1, GAP_W=1 and PULSE_W=7, GAP_W=3. Expect low widths of 1/7 cycles, gaps of 1/3 cycles, and capture on the last P2 cycle in both.
